ps2_mouse_init: RTL and testbench

PS2_MOUSE_INIT -- requirements
Module: ps2_mouse_init

---
 rtl/ps2_mouse_init.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_mouse_init.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse bring-up: reset the mouse (0xFF), expect FA/AA/00, enable streaming (0xF4),
// expect FA, then hand the bus to the packet receiver. Retries on any protocol failure.
module ps2_mouse_init #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int RETRY_MAX      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       stream_en,
   output logic       init_done,
   output logic       init_error,
   output logic       busy,
   output logic [2:0] retry_cnt
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    RETRY_LIM = 3'(RETRY_MAX);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_INHIBIT = 4'd1;
   localparam logic [3:0] S_REQ     = 4'd2;
   localparam logic [3:0] S_TX_BITS = 4'd3;
   localparam logic [3:0] S_TX_ACK  = 4'd4;
   localparam logic [3:0] S_RX      = 4'd5;
   localparam logic [3:0] S_CHECK   = 4'd6;
   localparam logic [3:0] S_DONE    = 4'd7;
   localparam logic [3:0] S_ERROR   = 4'd8;

   // {odd parity, data}; the stop bit is implied by leaving TX_BITS
   function automatic logic [8:0] tx_frame(input logic [7:0] b);
      return {~^b, b};
   endfunction

   logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
   logic          clk_s1_d, clk_s2_d, clk_prev_d, dat_s1_d, dat_s2_d;
   logic [3:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    tx_shift_q, tx_shift_d;
   logic [10:0]   rx_shift_q, rx_shift_d;
   logic [1:0]    step_q, step_d;
   logic [2:0]    retry_q, retry_d;
   logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic          stream_q, stream_d, done_q, done_d, error_q, error_d, busy_q, busy_d;

   logic          fall, fail, wait_state;
   logic [10:0]   rx_frame;
   logic [7:0]    exp_byte;

   always_comb begin
      clk_s1_d   = ps2_clk_i;
      clk_s2_d   = clk_s1_q;
      clk_prev_d = clk_s2_q;
      dat_s1_d   = ps2_data_i;
      dat_s2_d   = dat_s1_q;
   end

   assign fall     = clk_prev_q & ~clk_s2_q;
   assign rx_frame = {dat_s2_q, rx_shift_q[10:1]};

   always_comb begin
      case (step_q)
         2'd0:    exp_byte = 8'hFA;
         2'd1:    exp_byte = 8'hAA;
         2'd2:    exp_byte = 8'h00;
         default: exp_byte = 8'hFA;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      step_d     = step_q;
      retry_d    = retry_q;
      fail       = 1'b0;
      wait_state = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d    = S_INHIBIT;
            tx_shift_d = tx_frame(8'hFF);
            cnt_d      = '0;
            step_d     = 2'd0;
         end
         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               state_d = S_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_REQ: begin
            wait_state = 1'b1;
            if (fall) begin
               state_d   = S_TX_BITS;
               bit_cnt_d = 4'd0;
            end
         end
         S_TX_BITS: begin
            wait_state = 1'b1;
            if (fall) begin
               // edge while parity is on the wire: release data for the stop bit
               if (bit_cnt_q == 4'd8) begin
                  state_d = S_TX_ACK;
               end else begin
                  tx_shift_d = {1'b1, tx_shift_q[8:1]};
                  bit_cnt_d  = bit_cnt_q + 4'd1;
               end
            end
         end
         S_TX_ACK: begin
            wait_state = 1'b1;
            if (fall) begin
               if (!dat_s2_q) begin
                  state_d   = S_RX;
                  bit_cnt_d = 4'd0;
               end else begin
                  fail = 1'b1;
               end
            end
         end
         S_RX: begin
            wait_state = 1'b1;
            if (fall) begin
               rx_shift_d = rx_frame;
               if (bit_cnt_q == 4'd10) begin
                  if (!rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]))
                     state_d = S_CHECK;
                  else
                     fail = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_CHECK: begin
            if (rx_shift_q[8:1] != exp_byte) begin
               fail = 1'b1;
            end else begin
               cnt_d     = '0;
               bit_cnt_d = 4'd0;
               case (step_q)
                  2'd2: begin
                     state_d    = S_INHIBIT;
                     tx_shift_d = tx_frame(8'hF4);
                     step_d     = 2'd3;
                  end
                  2'd3:    state_d = S_DONE;
                  default: begin
                     state_d = S_RX;
                     step_d  = step_q + 2'd1;
                  end
               endcase
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase

      // one counter serves both the inhibit timer and the edge-to-edge watchdog
      if (wait_state) begin
         if (fall)
            cnt_d = '0;
         else if (cnt_q == TMO_LAST)
            fail = 1'b1;
         else
            cnt_d = cnt_q + CW'(1);
      end

      if (fail) begin
         state_d    = (retry_q < RETRY_LIM) ? S_INHIBIT : S_ERROR;
         retry_d    = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
         tx_shift_d = tx_frame(8'hFF);
         cnt_d      = '0;
         bit_cnt_d  = 4'd0;
         step_d     = 2'd0;
      end

      clk_oe_d  = (state_d == S_INHIBIT);
      data_oe_d = (state_d == S_REQ) || ((state_d == S_TX_BITS) && !tx_shift_d[0]);
      stream_d  = (state_d == S_DONE);
      done_d    = (state_d == S_DONE);
      error_d   = (state_d == S_ERROR);
      busy_d    = (state_d != S_DONE) && (state_d != S_ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1_q   <= 1'b0;
         clk_s2_q   <= 1'b0;
         clk_prev_q <= 1'b0;
         dat_s1_q   <= 1'b0;
         dat_s2_q   <= 1'b0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= 4'd0;
         tx_shift_q <= 9'd0;
         rx_shift_q <= 11'd0;
         step_q     <= 2'd0;
         retry_q    <= 3'd0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         stream_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         clk_prev_q <= clk_prev_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         step_q     <= step_d;
         retry_q    <= retry_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         stream_q   <= stream_d;
         done_q     <= done_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign stream_en   = stream_q;
   assign init_done   = done_q;
   assign init_error  = error_q;
   assign busy        = busy_q;
   assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init.sv
// Bench for ps2_mouse_init: a behavioural PS/2 mouse on open-drain lines, with a queue of
// expected host command frames checked as the mouse clocks each frame in.
module tb_ps2_mouse_init;

   localparam int INH = 50;
   localparam int TMO = 400;
   localparam int RMX = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_i, ps2_data_i;
   logic       ps2_clk_oe, ps2_data_oe, stream_en, init_done, init_error, busy;
   logic [2:0] retry_cnt;

   assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_i = dev_data & ~ps2_data_oe;

   ps2_mouse_init #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMX)) dut (
      .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .stream_en(stream_en),
      .init_done(init_done), .init_error(init_error), .busy(busy), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [8:0] exp_q[$];
   int         inh_run = 0;
   int         last_inh = 0;

   // length of the most recent completed clock-inhibit window
   always @(negedge clk) begin
      if (reset) inh_run <= 0;
      else if (ps2_clk_oe) inh_run <= inh_run + 1;
      else if (inh_run != 0) begin
         last_inh <= inh_run;
         inh_run  <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      step(3);
      reset = 1'b0;
      exp_q.delete();
      step(1);
   endtask

   // wait for a request-to-send, clock the frame in and acknowledge it
   task automatic host_frame(output logic [9:0] bits, output logic start, output bit ok);
      int t;
      bits = '0; start = 1'b1; ok = 1'b0; t = 0;
      while (!ps2_clk_oe && t < 3000) begin step(1); t++; end
      if (!ps2_clk_oe) return;
      t = 0;
      while (ps2_clk_oe && t < 3000) begin step(1); t++; end
      if (ps2_clk_oe) return;
      step(2);
      start = ps2_data_i;
      for (int k = 0; k < 10; k++) begin
         dev_clk = 1'b0; step(10);
         dev_clk = 1'b1; step(9);
         bits[k] = ps2_data_i;
         step(1);
      end
      dev_data = 1'b0; step(2);
      dev_clk = 1'b0; step(10);
      dev_clk = 1'b1; dev_data = 1'b1; step(10);
      ok = 1'b1;
   endtask

   task automatic check_host(input bit chk_inh);
      logic [9:0] bits;
      logic       start;
      bit         ok;
      logic [8:0] e;
      host_frame(bits, start, ok);
      chk("host_frame_seen", 32'(ok), 32'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("cmd_byte", 32'(bits[7:0]), 32'(e[7:0]));
         chk("cmd_parity", 32'(bits[8]), 32'(e[8]));
         chk("stop_released", 32'(bits[9]), 32'd1);
         chk("start_bit", 32'(start), 32'd0);
         if (chk_inh) chk("inhibit_len", 32'(last_inh), 32'(INH));
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         dev_data = f[i]; step(5);
         dev_clk = 1'b0; step(10);
         dev_clk = 1'b1; step(5);
      end
      dev_data = 1'b1;
      step(5);
   endtask

   task automatic chk_done(input int exp_retry);
      step(8);
      chk("init_done", 32'(init_done), 32'd1);
      chk("stream_en", 32'(stream_en), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("init_error_done", 32'(init_error), 32'd0);
      chk("retry_cnt_done", 32'(retry_cnt), 32'(exp_retry));
      chk("oe_done", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
   endtask

   initial begin
      int t;
      // reset state
      step(2);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      chk("rst_stream", 32'(stream_en), 32'd0);
      chk("rst_done", 32'(init_done), 32'd0);
      chk("rst_error", 32'(init_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_retry", 32'(retry_cnt), 32'd0);
      reset = 1'b0;
      step(3);
      chk("busy_after_rst", 32'(busy), 32'd1);

      // nominal bring-up
      exp_q.push_back(9'h1FF);
      exp_q.push_back(9'h0F4);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      send_frame(8'hAA, 1'b0);
      send_frame(8'h00, 1'b0);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      chk_done(0);

      // mouse answers 0xF4 with resend: one retry, then nominal
      do_reset();
      exp_q.push_back(9'h1FF);
      exp_q.push_back(9'h0F4);
      exp_q.push_back(9'h1FF);
      exp_q.push_back(9'h0F4);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      send_frame(8'hAA, 1'b0);
      send_frame(8'h00, 1'b0);
      check_host(1'b1);
      send_frame(8'hFE, 1'b0);
      step(5);
      chk("retry_after_fe", 32'(retry_cnt), 32'd1);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      send_frame(8'hAA, 1'b0);
      send_frame(8'h00, 1'b0);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      chk_done(1);

      // ack byte with broken parity
      do_reset();
      exp_q.push_back(9'h1FF);
      exp_q.push_back(9'h1FF);
      check_host(1'b1);
      send_frame(8'hFA, 1'b1);
      step(5);
      chk("retry_after_par", 32'(retry_cnt), 32'd1);
      chk("busy_after_par", 32'(busy), 32'd1);
      check_host(1'b1);

      // reset while the 0xF4 frame is being shifted out
      do_reset();
      exp_q.push_back(9'h1FF);
      check_host(1'b1);
      send_frame(8'hFA, 1'b0);
      send_frame(8'hAA, 1'b0);
      send_frame(8'h00, 1'b0);
      t = 0;
      while (!ps2_clk_oe && t < 3000) begin step(1); t++; end
      while (ps2_clk_oe && t < 3000) begin step(1); t++; end
      chk("f4_request_seen", 32'(t < 3000), 32'd1);
      step(2);
      dev_clk = 1'b0;
      step(6);
      chk("tx_bit0_driven", 32'(ps2_data_oe), 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      step(1);
      dev_clk = 1'b1;
      step(3);
      reset = 1'b0;
      exp_q.push_back(9'h1FF);
      check_host(1'b1);
      chk("retry_after_rst", 32'(retry_cnt), 32'd0);

      // silent mouse: every attempt times out
      do_reset();
      t = 0;
      while (!init_error && t < 5000) begin step(1); t++; end
      chk("silent_error", 32'(init_error), 32'd1);
      chk("silent_retry", 32'(retry_cnt), 32'(RMX + 1));
      chk("silent_busy", 32'(busy), 32'd0);
      chk("silent_stream", 32'(stream_en), 32'd0);
      chk("silent_done", 32'(init_done), 32'd0);
      step(20);
      chk("silent_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("silent_sticky", 32'(init_error), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
